// File: rtl/fixed_div_nb.sv
// Iterative signed divider: 2*WIDTH-bit dividend / WIDTH-bit divisor, one quotient bit per cycle.
// Define FIXED_DIV_SAT_EN to saturate the quotient on divide-by-zero or overflow instead of zeroing.
module fixed_div_nb #(
    parameter int unsigned WIDTH = 26
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic [2*WIDTH-1:0] din1,
    input  logic [WIDTH-1:0]   din2,
    input  logic               din_valid,
    output logic               din_ready,
    output logic [WIDTH-1:0]   dout_quo,
    output logic [WIDTH-1:0]   dout_rem,
    output logic               dout_dbz,
    output logic               dout_ovf,
    output logic               dout_valid
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    CntLast = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] QMax    = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] QMin    = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH:0]     hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               sq_q, sq_d;
    logic               sr_q, sr_d;
    logic               dbz_q, dbz_d;
    logic               uovf_q, uovf_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               res_dbz_q, res_dbz_d;
    logic               res_ovf_q, res_ovf_d;
    logic               valid_q, valid_d;

    logic [2*WIDTH-1:0] dvd_abs;
    logic [WIDTH-1:0]   dvs_abs;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic               ge;
    logic [WIDTH-1:0]   q_signed;
    logic [WIDTH-1:0]   r_signed;
    logic               ovf_fix;
    logic               res_neg;

    // Magnitudes are unsigned, so the most negative operands are exact.
    assign dvd_abs = din1[2*WIDTH-1] ? ((2*WIDTH)'(0) - din1) : din1;
    assign dvs_abs = din2[WIDTH-1] ? (WIDTH'(0) - din2) : din2;

    // Lower dividend half shifts out MSB-first while quotient bits shift in at the LSB.
    assign shifted = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
    assign ge      = shifted >= {1'b0, dvs_q};
    assign diff    = shifted - {1'b0, dvs_q};

    assign q_signed = sq_q ? (WIDTH'(0) - lo_q) : lo_q;
    assign r_signed = sr_q ? (WIDTH'(0) - hi_q[WIDTH-1:0]) : hi_q[WIDTH-1:0];
    assign ovf_fix  = ~dbz_q & (uovf_q | (~sq_q & lo_q[WIDTH-1])
                      | (sq_q & lo_q[WIDTH-1] & (|lo_q[WIDTH-2:0])));
    // Sign of the true result: dividend sign for divide-by-zero, quotient sign otherwise.
    assign res_neg  = dbz_q ? sr_q : sq_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dvs_d     = dvs_q;
        sq_d      = sq_q;
        sr_d      = sr_q;
        dbz_d     = dbz_q;
        uovf_d    = uovf_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        res_dbz_d = res_dbz_q;
        res_ovf_d = res_ovf_q;
        valid_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (din_valid) begin
                    hi_d    = {1'b0, dvd_abs[2*WIDTH-1:WIDTH]};
                    lo_d    = dvd_abs[WIDTH-1:0];
                    dvs_d   = dvs_abs;
                    sq_d    = din1[2*WIDTH-1] ^ din2[WIDTH-1];
                    sr_d    = din1[2*WIDTH-1];
                    dbz_d   = (din2 == '0);
                    uovf_d  = (dvd_abs[2*WIDTH-1:WIDTH] >= dvs_abs);
                    cnt_d   = '0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                hi_d  = ge ? diff : shifted;
                lo_d  = {lo_q[WIDTH-2:0], ge};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CntLast) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                res_dbz_d = dbz_q;
                res_ovf_d = ovf_fix;
                if (dbz_q || ovf_fix) begin
                    rem_d = '0;
`ifdef FIXED_DIV_SAT_EN
                    quo_d = res_neg ? QMin : QMax;
`else
                    quo_d = res_neg ? '0 : '0;
`endif
                end else begin
                    quo_d = q_signed;
                    rem_d = r_signed;
                end
                valid_d = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            dvs_q     <= '0;
            sq_q      <= 1'b0;
            sr_q      <= 1'b0;
            dbz_q     <= 1'b0;
            uovf_q    <= 1'b0;
            quo_q     <= '0;
            rem_q     <= '0;
            res_dbz_q <= 1'b0;
            res_ovf_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            dvs_q     <= dvs_d;
            sq_q      <= sq_d;
            sr_q      <= sr_d;
            dbz_q     <= dbz_d;
            uovf_q    <= uovf_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            res_dbz_q <= res_dbz_d;
            res_ovf_q <= res_ovf_d;
            valid_q   <= valid_d;
        end
    end

    assign din_ready  = (state_q == StIdle);
    assign dout_quo   = quo_q;
    assign dout_rem   = rem_q;
    assign dout_dbz   = res_dbz_q;
    assign dout_ovf   = res_ovf_q;
    assign dout_valid = valid_q;

endmodule
